// File: rtl/chroma_key_mem_ctrl.sv
// Chroma-key video pipeline: reads a camera frame buffer and a background store,
// replaces green-dominant camera pixels with background, and counts keyed pixels per frame.
module chroma_key_mem_ctrl #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int BG_W   = 160,
  parameter int BG_H   = 120,
  parameter int NUM_BG = 4,
  parameter int BGA_W  = 17,
  localparam int SEL_W = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  input  logic             DE,
  input  logic             upscale,
  input  logic [SEL_W-1:0] bg_sel,
  input  logic             key_en,
  input  logic [3:0]       key_margin,
  output logic             rclk,
  output logic             d_en,
  output logic [16:0]      rAddr,
  input  logic [15:0]      rData,
  output logic [BGA_W-1:0] bg_rAddr,
  input  logic [15:0]      bg_rData,
  output logic [11:0]      camera_pixel,
  output logic             pixel_de,
  output logic             key_hit,
  output logic [16:0]      frame_key_count,
  output logic             frame_done
);

  assign rclk = clk;

  logic [SEL_W-1:0] bg_idx;
  logic [SEL_W-1:0] sel_c;
  logic [SEL_W-1:0] idx_c;
  logic             fs_c;
  logic [9:0]       sx;
  logic [9:0]       sy;
  logic [10:0]      x_lim;
  logic [10:0]      y_lim;
  logic             in_win;
  logic [16:0]      addr_c;
  logic [BGA_W-1:0] bg_addr_c;

  // On a frame-start pixel the freshly selected background is used immediately.
  always_comb begin
    sel_c = bg_sel;
    if (32'(bg_sel) > 32'(NUM_BG - 1)) sel_c = SEL_W'(NUM_BG - 1);
    fs_c   = (x_pixel == 10'd0) && (y_pixel == 10'd0);
    idx_c  = fs_c ? sel_c : bg_idx;
    sx     = upscale ? (x_pixel >> 1) : x_pixel;
    sy     = upscale ? (y_pixel >> 1) : y_pixel;
    x_lim  = upscale ? 11'(2 * SRC_W) : 11'(SRC_W);
    y_lim  = upscale ? 11'(2 * SRC_H) : 11'(SRC_H);
    in_win = ({1'b0, x_pixel} < x_lim) && ({1'b0, y_pixel} < y_lim);
    addr_c = in_win ? (17'(sy) * 17'(SRC_W) + 17'(sx)) : 17'd0;
    bg_addr_c = BGA_W'(idx_c) * BGA_W'(BG_W * BG_H);
    if (in_win) bg_addr_c = bg_addr_c + BGA_W'(sy >> 1) * BGA_W'(BG_W) + BGA_W'(sx >> 1);
  end

  logic       de1, fs1, ken1;
  logic [3:0] km1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg_idx   <= '0;
      d_en     <= 1'b0;
      rAddr    <= '0;
      bg_rAddr <= '0;
      de1      <= 1'b0;
      fs1      <= 1'b0;
      ken1     <= 1'b0;
      km1      <= '0;
    end else begin
      if (fs_c) bg_idx <= sel_c;
      d_en     <= in_win;
      rAddr    <= addr_c;
      bg_rAddr <= bg_addr_c;
      de1      <= DE;
      fs1      <= fs_c;
      ken1     <= key_en;
      km1      <= key_margin;
    end
  end

  // Stage 2: memories return data; control rides along with it.
  logic       de2, fs2, den2, ken2;
  logic [3:0] km2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de2  <= 1'b0;
      fs2  <= 1'b0;
      den2 <= 1'b0;
      ken2 <= 1'b0;
      km2  <= '0;
    end else begin
      de2  <= de1;
      fs2  <= fs1;
      den2 <= d_en;
      ken2 <= ken1;
      km2  <= km1;
    end
  end

  logic [3:0]  r, g, b;
  logic        key_c;
  logic        hit_c;
  logic [11:0] pix_c;

  // Margin sums are 5 bits wide so r+margin never wraps.
  always_comb begin
    r     = rData[15:12];
    g     = rData[10:7];
    b     = rData[4:1];
    key_c = ken2 && den2
            && ({1'b0, g} > ({1'b0, r} + {1'b0, km2}))
            && ({1'b0, g} > ({1'b0, b} + {1'b0, km2}));
    hit_c = key_c && de2;
    pix_c = 12'h000;
    if (de2) pix_c = key_c ? {bg_rData[15:12], bg_rData[10:7], bg_rData[4:1]} : {r, g, b};
  end

  logic [16:0] key_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      camera_pixel    <= '0;
      pixel_de        <= 1'b0;
      key_hit         <= 1'b0;
      frame_done      <= 1'b0;
      frame_key_count <= '0;
      key_cnt         <= '0;
    end else begin
      camera_pixel <= pix_c;
      pixel_de     <= de2;
      key_hit      <= hit_c;
      if (fs2) begin
        frame_key_count <= key_cnt;
        frame_done      <= 1'b1;
        key_cnt         <= hit_c ? 17'd1 : 17'd0;
      end else begin
        frame_done <= 1'b0;
        if (hit_c && (key_cnt != '1)) key_cnt <= key_cnt + 17'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{rData[11], rData[6:5], rData[0],
                         bg_rData[11], bg_rData[6:5], bg_rData[0]};

endmodule
